// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result valid-ready bundle between the register-read stage, alu_pipe and writeback.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    modport master (
        output in_valid, a, b, op, shamt, out_ready,
        input  in_ready, out_valid, out, flags
    );
    modport slave (
        input  in_valid, a, b, op, shamt, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit multi-cycle ALU with valid/ready handshake and registered {Z,N,C,V} flags.
// Define ALU_MUL_EN to build the iterative shift-and-add multiplier (op 11); otherwise op 11 is reserved.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_NEG = 4'd2, OP_AND = 4'd3;
    localparam logic [3:0] OP_ORR = 4'd4, OP_EOR = 4'd5, OP_LSL = 4'd6, OP_LSR = 4'd7;
    localparam logic [3:0] OP_ASR = 4'd8, OP_ADC = 4'd9, OP_SBC = 4'd10;
    logic [WIDTH-1:0] out_q, res_d, opb;
    logic [3:0]       flags_q, flags_d;
    logic             valid_q, carry_q, cin, c_d, v_d, idle, accept;
    logic [WIDTH:0]   sum, shl, shr, asr;
    // Subtraction reuses the adder as a + ~b + cin; shifts carry one guard bit to catch the last bit out.
    always_comb begin
        opb = (bus.op == OP_SUB || bus.op == OP_SBC) ? ~bus.b : bus.b;
        cin = (bus.op == OP_SUB) | ((bus.op == OP_ADC || bus.op == OP_SBC) & carry_q);
        sum = {1'b0, bus.a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        shl = {1'b0, bus.a} << bus.shamt;
        shr = {bus.a, 1'b0} >> bus.shamt;
        asr = $signed({bus.a, 1'b0}) >>> bus.shamt;
        res_d = '0;
        c_d = 1'b0;
        v_d = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res_d = sum[WIDTH-1:0];
                c_d = sum[WIDTH];
                v_d = (bus.a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_NEG: res_d = ~bus.b;
            OP_AND: res_d = bus.a & bus.b;
            OP_ORR: res_d = bus.a | bus.b;
            OP_EOR: res_d = bus.a ^ bus.b;
            OP_LSL: {c_d, res_d} = shl;
            OP_LSR: {res_d, c_d} = shr;
            OP_ASR: {res_d, c_d} = asr;
            default: res_d = '0;
        endcase
        flags_d = {res_d == '0, res_d[WIDTH-1], c_d, v_d};
    end
`ifdef ALU_MUL_EN
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   mc_q, mp_q;
    logic [2*WIDTH-1:0] acc_q, prod;
    assign idle = state_q == IDLE;
    assign prod = acc_q + (mp_q[cnt_q] ? {{WIDTH{1'b0}}, mc_q} << cnt_q : '0);
`else
    assign idle = 1'b1;
`endif
    assign bus.in_ready  = idle && (!valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out       = out_q;
    assign bus.flags     = flags_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            carry_q <= 1'b0;
`ifdef ALU_MUL_EN
            state_q <= IDLE;
            cnt_q <= '0;
            mc_q <= '0;
            mp_q <= '0;
            acc_q <= '0;
`endif
        end else begin
            if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
                carry_q <= flags_q[1];
            end
`ifdef ALU_MUL_EN
            case (state_q)
                IDLE: begin
                    if (accept && bus.op == OP_MUL) begin
                        state_q <= BUSY;
                        cnt_q <= '0;
                        acc_q <= '0;
                        mc_q <= bus.a;
                        mp_q <= bus.b;
                    end else if (accept) begin
                        out_q <= res_d;
                        flags_q <= flags_d;
                        valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    acc_q <= prod;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= DONE;
                end
                DONE: begin
                    out_q <= acc_q[WIDTH-1:0];
                    flags_q <= {acc_q[WIDTH-1:0] == '0, acc_q[WIDTH-1],
                                |acc_q[2*WIDTH-1:WIDTH], |acc_q[2*WIDTH-1:WIDTH]};
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`else
            if (accept) begin
                out_q <= res_d;
                flags_q <= flags_d;
                valid_q <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe plus a cycle-level reference model compared every cycle.
module tb_alu_pipe;
    localparam int W = 8;
    localparam int SHW = 3;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Arithmetic reference written with plain integers and signed ranges.
    function automatic void ref_alu(input int o, input int ai, input int bi, input int sh, input int cin,
                                    output int r, output logic [3:0] f);
        int m, s, sa, sb, sv, p;
        logic c, v;
        m = 1 << W;
        sa = (ai >= m / 2) ? ai - m : ai;
        sb = (bi >= m / 2) ? bi - m : bi;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        sv = 0;
        case (o)
            0, 9: begin
                s = ai + bi + ((o == 9) ? cin : 0);
                sv = sa + sb + ((o == 9) ? cin : 0);
                r = s % m;
                c = s >= m;
                v = (sv >= m / 2) || (sv < -(m / 2));
            end
            1, 10: begin
                s = ai + (m - 1 - bi) + ((o == 1) ? 1 : cin);
                sv = sa - sb - ((o == 1) ? 0 : 1 - cin);
                r = s % m;
                c = s >= m;
                v = (sv >= m / 2) || (sv < -(m / 2));
            end
            2: r = m - 1 - bi;
            3: r = ai & bi;
            4: r = ai | bi;
            5: r = ai ^ bi;
            6: begin
                r = (ai << sh) % m;
                c = (sh > 0) ? 1'((ai >> (W - sh)) & 1) : 1'b0;
            end
            7, 8: begin
                r = (o == 7) ? (ai >> sh) : ((sa >>> sh) & (m - 1));
                c = (sh > 0) ? 1'((ai >> (sh - 1)) & 1) : 1'b0;
            end
            11: if (MUL_EN) begin
                p = ai * bi;
                r = p % m;
                c = (p / m) != 0;
                v = c;
            end
            default: r = 0;
        endcase
        f = {r == 0, r >= m / 2, c, v};
    endfunction
    logic         m_valid = 1'b0, m_carry = 1'b0;
    logic [W-1:0] m_out = '0, p_out = '0;
    logic [3:0]   m_flags = '0, p_flags = '0;
    int           m_busy = 0;
    initial forever begin
        int r;
        logic [3:0] f;
        logic acc, ret, nc;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_carry = 1'b0;
            m_out = '0;
            m_flags = '0;
            m_busy = 0;
        end else begin
            acc = bus.in_valid && (m_busy == 0) && (!m_valid || bus.out_ready);
            ret = m_valid && bus.out_ready;
            nc = ret ? m_flags[1] : m_carry;
            if (ret) m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid = 1'b1;
                    m_out = p_out;
                    m_flags = p_flags;
                end
            end
            if (acc) begin
                ref_alu(int'(bus.op), int'(bus.a), int'(bus.b), int'(bus.shamt), int'(m_carry), r, f);
                if (MUL_EN && bus.op == 4'd11) begin
                    m_busy = W + 1;
                    p_out = W'(r);
                    p_flags = f;
                end else begin
                    m_valid = 1'b1;
                    m_out = W'(r);
                    m_flags = f;
                end
            end
            m_carry = nc;
        end
    end
    initial forever begin
        @(negedge clk);
        #1;
        chk("cmp_out_valid", bus.out_valid, m_valid);
        chk("cmp_in_ready", bus.in_ready, (m_busy == 0) && (!m_valid || bus.out_ready));
        if (m_valid) begin
            chk("cmp_out", bus.out, m_out);
            chk("cmp_flags", bus.flags, m_flags);
        end
    end
    task automatic do_op(input string nm, input logic [3:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic [SHW-1:0] sh, input logic [W-1:0] eo, input logic [3:0] ef, input int elat);
        int n;
        logic rdy_seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = ai;
        bus.b = bi;
        bus.shamt = sh;
        #1 chk({nm, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = ~ai;
        bus.b = ~bi;
        n = 1;
        rdy_seen = 1'b0;
        #1;
        while (!bus.out_valid && n < 40) begin
            rdy_seen |= bus.in_ready;
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency"}, n, elat);
        chk({nm, "_out"}, bus.out, eo);
        chk({nm, "_flags"}, bus.flags, ef);
        if (elat > 1) chk({nm, "_busy_ready"}, rdy_seen, 0);
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end
    initial begin
        int r;
        logic [3:0] f;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        bus.shamt = '0;
        ref_alu(0, 8'hFF, 8'h01, 0, 0, r, f);
        chk("model_add", {r[7:0], 4'h0, f}, {8'h00, 4'h0, 4'b1010});
        ref_alu(10, 8'h05, 8'h03, 0, 0, r, f);
        chk("model_sbc", {r[7:0], 4'h0, f}, {8'h01, 4'h0, 4'b0010});
        ref_alu(8, 8'h81, 0, 3, 0, r, f);
        chk("model_asr", {r[7:0], 4'h0, f}, {8'hF0, 4'h0, 4'b0100});
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out", bus.out, 0);
        chk("rst_flags", bus.flags, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1010, 1);
        do_op("sub_80_01", 4'd1, 8'h80, 8'h01, 3'd0, 8'h7F, 4'b0011, 1);
        do_op("adc_carry", 4'd9, 8'h00, 8'h00, 3'd0, 8'h01, 4'b0000, 1);
        do_op("asr_81_3", 4'd8, 8'h81, 8'h00, 3'd3, 8'hF0, 4'b0100, 1);
        do_op("lsl_81_1", 4'd6, 8'h81, 8'h00, 3'd1, 8'h02, 4'b0010, 1);
        do_op("lsr_81_1", 4'd7, 8'h81, 8'h00, 3'd1, 8'h40, 4'b0010, 1);
        do_op("lsl_sh0", 4'd6, 8'h81, 8'h00, 3'd0, 8'h81, 4'b0100, 1);
        do_op("add_ovf", 4'd0, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0101, 1);
        do_op("sbc_nocarry", 4'd10, 8'h05, 8'h03, 3'd0, 8'h01, 4'b0010, 1);
        do_op("neg_0f", 4'd2, 8'h00, 8'h0F, 3'd0, 8'hF0, 4'b0100, 1);
        do_op("eor_zero", 4'd5, 8'hAA, 8'hAA, 3'd0, 8'h00, 4'b1000, 1);
        do_op("and_mix", 4'd3, 8'hF3, 8'h3C, 3'd0, 8'h30, 4'b0000, 1);
        do_op("reserved13", 4'd13, 8'h12, 8'h34, 3'd2, 8'h00, 4'b1000, 1);
        do_op("mul_10_10", 4'd11, 8'h10, 8'h10, 3'd0, 8'h00, MUL_EN ? 4'b1011 : 4'b1000, MUL_EN ? 9 : 1);
        do_op("mul_0d_0b", 4'd11, 8'h0D, 8'h0B, 3'd0, MUL_EN ? 8'h8F : 8'h00,
              MUL_EN ? 4'b0100 : 4'b1000, MUL_EN ? 9 : 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 4'd0;
        bus.a = 8'h01;
        bus.b = 8'h02;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out", bus.out, 8'h03);
            chk("bp_flags", bus.flags, 4'b0000);
            chk("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.op = 4'd4;
        bus.a = 8'hF0;
        bus.b = 8'h0F;
        #1 chk("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("b2b_valid", bus.out_valid, 1);
        chk("b2b_out", bus.out, 8'hFF);
        chk("b2b_flags", bus.flags, 4'b0100);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 4'd11;
        bus.a = 8'h10;
        bus.b = 8'h10;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out", bus.out, 0);
        chk("arst_flags", bus.flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1 chk("arst_in_ready", bus.in_ready, 1);
        do_op("add_after_rst", 4'd0, 8'h01, 8'h02, 3'd0, 8'h03, 4'b0000, 1);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
